// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl
//   Sequences capture of camera frames into a two-bank (ping-pong) frame
//   buffer feeding the MobileNet datapath. A frame is captured into a free
//   bank after a vsync rise. A completed bank is handed to the consumer with
//   a ready/done handshake. Frames are dropped when no bank is free.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_start / i_stop      one-cycle pulses: arm capture / stop after frame
//   i_vsync               camera vertical sync (level, i_clk domain)
//   i_pixelValid, i_pixel pixel stream from the camera reader
//   o_wrEn/Bank/Addr/Data buffer write port (1-cycle latency from pixel)
//   o_frameReady          o_readBank holds a complete frame
//   o_readBank            bank presented to the consumer
//   i_frameDone           consumer releases o_readBank
//   o_busy                controller not idle
//   o_dropCount           dropped/aborted frames, saturating at 255
module frame_capture_ctrl #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_vsync,
    input  logic              i_pixelValid,
    input  logic [DATA_W-1:0] i_pixel,
    output logic              o_wrEn,
    output logic              o_wrBank,
    output logic [ADDR_W-1:0] o_wrAddr,
    output logic [DATA_W-1:0] o_wrData,
    output logic              o_frameReady,
    output logic              o_readBank,
    input  logic              i_frameDone,
    output logic              o_busy,
    output logic [7:0]        o_dropCount
);

    localparam int NPIX  = IMG_W * IMG_H;
    // One extra bit so the counter can park at NPIX once the frame is full.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] C_NPIX = CNT_W'(NPIX);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NPIX - 1);

    typedef enum logic [1:0] {IDLE, WAIT_VSYNC, CAPTURE} state_t;

    state_t            r_state;
    logic              r_vsyncD;
    logic              r_wrEn;
    logic              r_wrBank;
    logic [ADDR_W-1:0] r_wrAddr;
    logic [DATA_W-1:0] r_wrData;
    logic              r_frameReady;
    logic              r_readBank;
    logic [7:0]        r_dropCount;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_full;
    logic              r_oldest;    // bank that completed first when both are full
    logic              r_stopPend;

    logic       w_vsyncRise;
    logic [1:0] w_presented;
    logic [1:0] w_free;
    logic       w_accept;
    logic       w_complete;
    logic       w_abort;
    logic       w_release;
    logic       w_stop;
    logic [1:0] w_fullNext;

    assign w_vsyncRise = i_vsync & ~r_vsyncD;
    assign w_presented = {r_frameReady & r_readBank, r_frameReady & ~r_readBank};
    assign w_free      = ~r_full & ~w_presented;

    // A vsync rise ends the frame, so a pixel in that cycle is only taken
    // if it is the final one (completion wins over abort).
    assign w_accept   = (r_state == CAPTURE) && i_pixelValid && (r_cnt < C_NPIX) &&
                        (!w_vsyncRise || (r_cnt == C_LAST));
    assign w_complete = w_accept && (r_cnt == C_LAST);
    assign w_abort    = (r_state == CAPTURE) && w_vsyncRise && !w_complete;
    assign w_release  = i_frameDone && r_frameReady;
    assign w_stop     = r_stopPend || i_stop;

    // Completion and release may land in the same cycle; they always refer
    // to different banks since the write bank is never full or presented.
    always_comb begin
        w_fullNext = r_full;
        if (w_complete) w_fullNext[r_wrBank]   = 1'b1;
        if (w_release)  w_fullNext[r_readBank] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_vsyncD     <= 1'b0;
            r_wrEn       <= 1'b0;
            r_wrBank     <= 1'b0;
            r_wrAddr     <= '0;
            r_wrData     <= '0;
            r_frameReady <= 1'b0;
            r_readBank   <= 1'b0;
            r_dropCount  <= '0;
            r_cnt        <= '0;
            r_full       <= '0;
            r_oldest     <= 1'b0;
            r_stopPend   <= 1'b0;
        end else begin
            r_vsyncD <= i_vsync;
            r_wrEn   <= w_accept;
            r_full   <= w_fullNext;

            if (w_accept) begin
                r_wrAddr <= r_cnt[ADDR_W-1:0];
                r_wrData <= i_pixel;
                r_cnt    <= r_cnt + CNT_W'(1);
            end

            // Only becomes oldest if the other bank is not still waiting.
            if (w_complete && !w_fullNext[~r_wrBank])
                r_oldest <= r_wrBank;

            // Presentation looks at the pre-edge full flags, which enforces
            // the one-cycle low gap after a release.
            if (w_release) begin
                r_frameReady <= 1'b0;
            end else if (!r_frameReady && (|r_full)) begin
                r_frameReady <= 1'b1;
                r_readBank   <= (&r_full) ? r_oldest : r_full[1];
            end

            case (r_state)
                IDLE: begin
                    r_stopPend <= 1'b0;
                    if (i_start && !i_stop)
                        r_state <= WAIT_VSYNC;
                end
                WAIT_VSYNC: begin
                    if (i_stop) begin
                        r_state <= IDLE;
                    end else if (w_vsyncRise) begin
                        if (|w_free) begin
                            r_wrBank <= ~w_free[0];   // prefer bank 0
                            r_cnt    <= '0;
                            r_state  <= CAPTURE;
                        end else if (r_dropCount != 8'hFF) begin
                            r_dropCount <= r_dropCount + 8'd1;
                        end
                    end
                end
                CAPTURE: begin
                    if (i_stop)
                        r_stopPend <= 1'b1;
                    if (w_complete) begin
                        r_state <= w_stop ? IDLE : WAIT_VSYNC;
                        if (w_stop) r_stopPend <= 1'b0;
                    end else if (w_abort) begin
                        // Short frame: restart in the same bank.
                        r_cnt <= '0;
                        if (r_dropCount != 8'hFF)
                            r_dropCount <= r_dropCount + 8'd1;
                        if (w_stop) begin
                            r_state    <= IDLE;
                            r_stopPend <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_wrEn       = r_wrEn;
    assign o_wrBank     = r_wrBank;
    assign o_wrAddr     = r_wrAddr;
    assign o_wrData     = r_wrData;
    assign o_frameReady = r_frameReady;
    assign o_readBank   = r_readBank;
    assign o_busy       = (r_state != IDLE);
    assign o_dropCount  = r_dropCount;

endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
Sequences capture of camera frames into a two-bank (ping-pong) frame buffer that feeds the MobileNet datapath.
- Consumes the pixel stream from the camera reader (already in the i_clk domain).
- Generates buffer write strobes and addresses, and tracks ownership of each bank.
- Hands completed frames to the consumer with a ready/done handshake.
- Drops frames when no bank is free.

Parameters:
IMG_W, 320, pixels per row
IMG_H, 240, rows per frame
ADDR_W, 17, write address width per bank (must hold IMG_W*IMG_H-1)
DATA_W, 16, pixel width (RGB565)

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_start  in  1  one-cycle pulse: arm continuous capture
i_stop  in  1  one-cycle pulse: stop after current frame
i_vsync  in  1  camera vertical sync, level, synchronous to i_clk
i_pixelValid  in  1  pixel strobe from camera reader
i_pixel  in  DATA_W  pixel data
o_wrEn  out  1  buffer write enable
o_wrBank  out  1  bank being written
o_wrAddr  out  ADDR_W  write address within bank
o_wrData  out  DATA_W  write data
o_frameReady  out  1  bank o_readBank holds a complete frame for the consumer
o_readBank  out  1  bank presented to the consumer
i_frameDone  in  1  one-cycle pulse: consumer releases o_readBank
o_busy  out  1  state != IDLE
o_dropCount  out  8  dropped/aborted frame counter, saturates at 255

Behaviour:
- Reset (sync, active-high, highest priority, legal mid-frame): every output 0; state IDLE; pixel counter 0; write bank 0; both bank-full flags cleared. Any frame in progress is lost.
- vsync rise: registered detector; rise = i_vsync & ~vsync_d.
- FSM: IDLE, WAIT_VSYNC, CAPTURE.
- IDLE:
  - i_start -> WAIT_VSYNC.
  - i_start and i_stop in the same cycle: stop wins; stay IDLE.
- WAIT_VSYNC:
  - i_stop -> IDLE.
  - On vsync rise, a bank is free if its full flag = 0 and it is not presented. The lower-numbered free bank is preferred.
  - Free bank exists -> CAPTURE into it, counter = 0.
  - No free bank -> o_dropCount += 1 (saturating); stay in WAIT_VSYNC.
- CAPTURE, per i_pixelValid cycle while counter < IMG_W*IMG_H:
  - Next cycle: o_wrEn=1, o_wrAddr=counter, o_wrData=i_pixel, o_wrBank=write bank.
  - Counter increments. Write latency is exactly 1 cycle.
  - Pixels with counter >= IMG_W*IMG_H are ignored.
- Frame complete: the cycle the last write (addr IMG_W*IMG_H-1) issues, set that bank's full flag.
  - Stop pending (i_stop seen during CAPTURE) -> IDLE, else -> WAIT_VSYNC.
  - The pending-stop flag is cleared on entering IDLE.
- Short frame: vsync rise in CAPTURE before completion aborts the frame.
  - o_dropCount += 1; bank not marked full.
  - Restart capture in the same bank at counter 0 (stays CAPTURE).
  - With stop pending: go to IDLE instead.
- Presentation:
  - When o_frameReady=0 and some bank is full and not presented, the next cycle sets o_readBank to that bank and o_frameReady=1.
  - If both banks are full, present the bank that completed first (tracked by a 1-bit order flag).
- Release: i_frameDone while o_frameReady=1 clears that bank's full flag; o_frameReady=0 next cycle.
  - o_frameReady stays low for at least one cycle before the next presentation.
  - i_frameDone while o_frameReady=0 is ignored.
- Simultaneous frame-complete and i_frameDone:
  - Both take effect the same cycle.
  - The newly completed bank is presented after the mandatory one-cycle gap.
- o_readBank holds its value while o_frameReady=0.
- o_wrEn is never asserted to a bank that is full or presented.

Test Plan:
1. Reset, i_start, vsync pulse, 320x240 pixels with data=index -> 76800 writes, bank 0, addr 0..76799, 1-cycle latency; o_frameReady=1, o_readBank=0 one cycle after last write.
2. Consumer never asserts i_frameDone, camera sends 4 frames -> bank 0 presented, bank 1 filled, frames 3 and 4 dropped, o_dropCount=2, no o_wrEn after frame 2.
3. vsync rise after 1000 pixels -> o_dropCount=1, next write addr=0 same bank; full frame afterwards completes normally.
4. i_frameDone on the exact cycle frame 2 completes -> bank 0 released; o_frameReady low one cycle; then o_frameReady=1, o_readBank=1.
5. i_stop mid-capture -> frame finishes, o_frameReady=1, state IDLE, o_busy=0; later vsync produces no writes.
6. i_reset asserted at pixel 5000 -> all outputs 0 next cycle; after i_start plus a full frame, capture goes to bank 0 from addr 0.
